// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - request/result bundle for the bit-serial adder controller
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sharing one full_adder cell across all bit positions
module full_adder (
    input  logic a,
    input  logic b,
    input  logic Cin,
    output logic y,
    output logic Cout
);
    assign y    = a ^ b ^ Cin;
    assign Cout = (a & b) | (Cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_acc;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_y;
    logic             w_cout;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_load;
    logic             w_step;
    logic             w_finish;
    logic             w_busy;
    logic             w_done;

    full_adder u_fa (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .Cin  (r_c),
        .y    (w_y),
        .Cout (w_cout)
    );

    // The new sum bit enters at the MSB; after WIDTH steps bit 0 has reached the LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_acc_next = w_y;
        end else begin : g_wn
            assign w_acc_next = {w_y, r_acc[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_finish = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_acc  <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_load) begin
            r_sa  <= bus.a;
            r_sb  <= bus.b;
            r_c   <= bus.cin;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_step) begin
            r_acc <= w_acc_next;
            r_c   <= w_cout;
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_cnt <= r_cnt + CW'(1);
            // Result registers move only here, so they hold through later additions.
            if (w_finish) begin
                r_sum  <= w_acc_next;
                r_cout <= w_cout;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    typedef struct packed {
        logic       cout;
        logic [7:0] sum;
    } exp_t;

    exp_t       sb8[$];
    logic [1:0] sb1[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = cin;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        bus8.cin   = 1'($urandom);
    endtask

    task automatic wait_done8(output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            if (bus8.done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b expected all zero",
                     bus8.busy, bus8.done, bus8.sum, bus8.cout);
        end
        n_checks++;
        if ({bus1.busy, bus1.done, bus1.sum, bus1.cout} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_w1: got busy=%b done=%b sum=%h cout=%b expected all zero",
                     bus1.busy, bus1.done, bus1.sum, bus1.cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int nb = 0;
        int nd = 0;
        int at = -1;
        exp_t e;
        sb8.push_back('{cout: 1'b0, sum: 8'h7F});
        start8(8'h35, 8'h4A, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (bus8.busy === 1'b1) nb++;
            if (bus8.done === 1'b1) begin
                nd++;
                at = i;
                n_checks++;
                if (sb8.size() == 0) begin
                    n_fail++;
                    $display("FAIL basic_unexpected_done: got done with empty scoreboard, expected none");
                end else begin
                    e = sb8.pop_front();
                    if ({bus8.cout, bus8.sum} !== e) begin
                        n_fail++;
                        $display("FAIL basic_result: got cout=%b sum=%h expected cout=%b sum=%h",
                                 bus8.cout, bus8.sum, e.cout, e.sum);
                    end
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (nd != 1) begin
            n_fail++;
            $display("FAIL basic_done_count: got %0d expected 1", nd);
        end
        n_checks++;
        if (nb != 9) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d expected 9", nb);
        end
        n_checks++;
        if (at != 8) begin
            n_fail++;
            $display("FAIL basic_latency: got done %0d cycles after accept expected 8", at);
        end
    endtask

    task automatic test_carry;
        logic [7:0] ta[3] = '{8'hFF, 8'hFF, 8'h00};
        logic [7:0] tb[3] = '{8'h01, 8'hFF, 8'h00};
        logic       tc[3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] ts[3] = '{8'h00, 8'hFF, 8'h01};
        logic       to[3] = '{1'b1, 1'b1, 1'b0};
        bit seen;
        int cyc;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            sb8.push_back('{cout: to[k], sum: ts[k]});
            start8(ta[k], tb[k], tc[k]);
            wait_done8(seen, cyc);
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL carry_timeout[%0d]: got no done expected done", k);
                sb8.delete();
            end else begin
                e = sb8.pop_front();
                if ({bus8.cout, bus8.sum} !== e) begin
                    n_fail++;
                    $display("FAIL carry_result[%0d]: got cout=%b sum=%h expected cout=%b sum=%h",
                             k, bus8.cout, bus8.sum, e.cout, e.sum);
                end
            end
        end
    endtask

    task automatic test_start_while_busy;
        int nd = 0;
        int d0 = -1;
        int d1 = -1;
        bit saw_idle = 1'b0;
        exp_t e;
        sb8.push_back('{cout: 1'b0, sum: 8'h30});
        sb8.push_back('{cout: 1'b0, sum: 8'hFF});
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'h10;
        bus8.b     = 8'h20;
        bus8.cin   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus8.a = 8'hAA;
                bus8.b = 8'h55;
            end
            if (bus8.done === 1'b1) begin
                nd++;
                if (d0 < 0) d0 = i; else d1 = i;
                n_checks++;
                if (sb8.size() == 0) begin
                    n_fail++;
                    $display("FAIL busy_extra_done: got done with empty scoreboard at %0d, expected none", i);
                end else begin
                    e = sb8.pop_front();
                    if ({bus8.cout, bus8.sum} !== e) begin
                        n_fail++;
                        $display("FAIL busy_result: got cout=%b sum=%h expected cout=%b sum=%h",
                                 bus8.cout, bus8.sum, e.cout, e.sum);
                    end
                end
            end
            if (bus8.busy !== 1'b1) saw_idle = 1'b1;
            else if (saw_idle && bus8.start) bus8.start = 1'b0;
        end
        bus8.start = 1'b0;
        n_checks++;
        if (nd != 2) begin
            n_fail++;
            $display("FAIL busy_done_count: got %0d expected 2", nd);
        end
        n_checks++;
        if (d1 - d0 != 10) begin
            n_fail++;
            $display("FAIL busy_throughput: got %0d cycles between dones expected 10", d1 - d0);
        end
        sb8.delete();
    endtask

    task automatic test_reset_mid;
        int nd = 0;
        bit seen;
        int cyc;
        exp_t e;
        start8(8'h0F, 8'h0F, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout} !== 11'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy=%b done=%b sum=%h cout=%b expected all zero",
                     bus8.busy, bus8.done, bus8.sum, bus8.cout);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus8.done !== 1'b0) nd++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done !== 1'b0) nd++;
        end
        n_checks++;
        if (nd != 0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d done cycles expected 0", nd);
        end
        sb8.push_back('{cout: 1'b0, sum: 8'h03});
        start8(8'h01, 8'h02, 1'b0);
        wait_done8(seen, cyc);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midreset_timeout: got no done expected done");
            sb8.delete();
        end else begin
            e = sb8.pop_front();
            if ({bus8.cout, bus8.sum} !== e) begin
                n_fail++;
                $display("FAIL midreset_result: got cout=%b sum=%h expected cout=%b sum=%h",
                         bus8.cout, bus8.sum, e.cout, e.sum);
            end
        end
    endtask

    task automatic test_result_hold;
        bit seen;
        int cyc;
        int viol = 0;
        exp_t e;
        sb8.push_back('{cout: 1'b0, sum: 8'h7F});
        start8(8'h35, 8'h4A, 1'b0);
        wait_done8(seen, cyc);
        n_checks++;
        if (!seen || sb8.size() == 0) begin
            n_fail++;
            $display("FAIL hold_first: got seen=%b expected done", seen);
            sb8.delete();
        end else begin
            e = sb8.pop_front();
            if ({bus8.cout, bus8.sum} !== e) begin
                n_fail++;
                $display("FAIL hold_first: got cout=%b sum=%h expected cout=%b sum=%h",
                         bus8.cout, bus8.sum, e.cout, e.sum);
            end
        end
        sb8.push_back('{cout: 1'b0, sum: 8'h02});
        start8(8'h01, 8'h01, 1'b0);
        cyc = 0;
        while (bus8.done !== 1'b1 && cyc < 40) begin
            if (bus8.sum !== 8'h7F) viol++;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL hold_stable: got %0d cycles with sum changed expected 0", viol);
        end
        n_checks++;
        if (cyc != 8) begin
            n_fail++;
            $display("FAIL hold_latency: got %0d expected 8", cyc);
        end
        n_checks++;
        e = sb8.pop_front();
        if ({bus8.cout, bus8.sum} !== e) begin
            n_fail++;
            $display("FAIL hold_update: got cout=%b sum=%h expected cout=%b sum=%h",
                     bus8.cout, bus8.sum, e.cout, e.sum);
        end
    endtask

    task automatic test_width1;
        logic [1:0] e;
        logic [1:0] v;
        for (int k = 0; k < 8; k++) begin
            v = 2'({1'b0, k[2]}) + 2'({1'b0, k[1]}) + 2'({1'b0, k[0]});
            sb1.push_back(v);
            @(negedge clk);
            bus1.start = 1'b1;
            bus1.a     = k[2];
            bus1.b     = k[1];
            bus1.cin   = k[0];
            @(negedge clk);
            bus1.start = 1'b0;
            n_checks++;
            if (bus1.done !== 1'b0 || bus1.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL w1_run[%0d]: got done=%b busy=%b expected done=0 busy=1",
                         k, bus1.done, bus1.busy);
            end
            @(negedge clk);
            e = sb1.pop_front();
            n_checks++;
            if (bus1.done !== 1'b1 || {bus1.cout, bus1.sum} !== e) begin
                n_fail++;
                $display("FAIL w1_result[%0d]: got done=%b cout=%b sum=%b expected done=1 cout=%b sum=%b",
                         k, bus1.done, bus1.cout, bus1.sum, e[1], e[0]);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        bit seen;
        int cyc;
        exp_t e;
        for (int k = 0; k < 1000; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            sb8.push_back(exp_t'(9'({1'b0, a}) + 9'({1'b0, b}) + 9'({8'd0, c})));
            start8(a, b, c);
            wait_done8(seen, cyc);
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL random_timeout[%0d]: got no done expected done", k);
                sb8.delete();
            end else begin
                e = sb8.pop_front();
                if ({bus8.cout, bus8.sum} !== e) begin
                    n_fail++;
                    $display("FAIL random[%0d]: a=%h b=%h cin=%b got cout=%b sum=%h expected cout=%b sum=%h",
                             k, a, b, c, bus8.cout, bus8.sum, e.cout, e.sum);
                end
            end
        end
    endtask

    initial begin
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.cin   = 1'b0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        bus1.cin   = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_start_while_busy();
        test_reset_mid();
        test_result_hold();
        test_width1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that shares one instance of the team's 1-bit `full_adder` cell (`a`, `b`, `Cin` -> `y`, `Cout`) across all bit positions of a WIDTH-bit addition. It latches two operands and a carry-in on a start request, then feeds one bit pair per clock through the full adder, LSB first, with a registered carry. It assembles the sum and reports completion with a single-cycle done pulse. It is the area-minimal alternative to a ripple-carry array of full adders.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 1
- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to begin an addition; sampled on rising clk edge
- a  in  WIDTH  operand A; sampled only when start is accepted
- b  in  WIDTH  operand B; sampled only when start is accepted
- cin  in  1  carry-in; sampled only when start is accepted
- busy  out  1  high while an addition is in progress (RUN or DONE state)
- done  out  1  one-cycle pulse; sum and cout are valid from this cycle onward
- sum  out  WIDTH  registered result, held until the next completion
- cout  out  1  registered final carry-out, held until the next completion

## Operation
- There is exactly one `full_adder` instance. Its inputs are the operand shift-register LSBs and the carry register. Its `y` and `Cout` are the only arithmetic path; no `+` operator is used.
- Internal state:
  - operand shift registers sa and sb (WIDTH each)
  - accumulating shift register acc (WIDTH)
  - carry register c
  - bit counter cnt, width $clog2(WIDTH+1)
  - FSM
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0. If start=1 at an edge: sa<=a, sb<=b, c<=cin, cnt<=0, acc<=0, go to RUN. Otherwise stay.
- RUN: each edge does the following, updated together:
  - acc <= {fa.y, acc[WIDTH-1:1]}
  - c <= fa.Cout
  - sa and sb shift right by one
  - cnt <= cnt+1
- RUN exit: on the edge where cnt==WIDTH-1, also load sum <= {fa.y, acc[WIDTH-1:1]} and cout <= fa.Cout, and go to DONE.
- DONE: done=1, busy=1. The next edge goes to IDLE unconditionally.
- start is ignored whenever busy=1, including in DONE. It is never queued.
- a, b and cin may change freely after acceptance without affecting the result.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1). Overflow appears only in cout; there is no other status.
- WIDTH=1 is legal: RUN lasts one cycle.

## Timing
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0
  - sa, sb, acc, c and cnt all cleared
  - An addition in progress is abandoned with no done pulse.
- Reset release: the first edge with rst_n=1 may accept start.
- Latency: start accepted at edge E0.
  - busy rises after E0.
  - Bit i is computed during the cycle ending at edge E0+1+i.
  - sum and cout update, and done rises, after edge E0+WIDTH.
  - done falls and busy falls after edge E0+WIDTH+1.
- Throughput: one addition per WIDTH+2 cycles. The earliest next accept is edge E0+WIDTH+2.
- sum and cout change only on the RUN->DONE edge and on reset. They are stable at all other times, including during a subsequent RUN.
- done is high for exactly one cycle per accepted start and never without one.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Basic add (WIDTH=8): reset, then start with a=0x35, b=0x4A, cin=0 -> after 8 RUN cycles, done pulses once; sum=0x7F, cout=0; busy high for 9 cycles.
- Full carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Start while busy: accept a=0x10, b=0x20. Hold start=1 and change operands to 0xAA/0x55 during RUN and DONE -> only one done, with sum=0x30. The second addition is accepted at the first IDLE edge and yields sum=0xFF.
- Reset mid-operation: accept a=0x0F, b=0x0F, assert rst_n=0 after 3 RUN cycles -> immediately busy=0, done=0, sum=0x00, cout=0 and no done pulse. After release, a=0x01, b=0x02 yields sum=0x03.
- Result hold: after sum=0x7F, start a new addition with a=0x01, b=0x01 -> sum stays 0x7F through all RUN cycles and changes to 0x02 exactly when done rises.
- WIDTH=1 instance: a=1, b=1, cin=1 -> done after edge E0+1; sum=1, cout=1. A randomized 1000-vector run at WIDTH=8 matches the a+b+cin reference model.
